bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that produces the four decimal digits (ones, tens, hundreds, thousands) fed to the display digit multiplexer. It accepts a 14-bit binary value on a start pulse and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It then presents registered, stable BCD digits with a done pulse. It sits between the arithmetic datapath (adder result) and the 4-digit seven-segment display path.

---
 rtl/bcd_converter_if.sv | 39 +++
 rtl/bcd_converter.sv | 110 +++++++++++
 tb/tb_bcd_converter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bcd_converter_if.sv
// Bundle of the binary-to-BCD converter's request and result signals.
// The master side issues start/bin; the slave side returns status and digits.
interface bcd_converter_if #(
    parameter int BIN_W = 14
);
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       one;
    logic [3:0]       ten;
    logic [3:0]       hunnid;
    logic [3:0]       thousand;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  overflow,
        input  one,
        input  ten,
        input  hunnid,
        input  thousand
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output overflow,
        output one,
        output ten,
        output hunnid,
        output thousand
    );
endinterface

// File: rtl/bcd_converter.sv
// Sequential double-dabble converter: 14-bit binary to four registered BCD
// digits, one bit per clock, saturating to 9999 when the input exceeds it.
module bcd_converter (
    input  logic           clk,
    input  logic           rst_n,
    bcd_converter_if.slave bus
);
    localparam int               BIN_W    = 14;
    localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(9999);
    localparam logic [15:0]      SAT_BCD  = 16'h9999;
    localparam logic [3:0]       CNT_LOAD = 4'(BIN_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [BIN_W-1:0] bin_reg, bin_next;
    logic [15:0]      scratch_reg, scratch_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             ovf_pending_reg, ovf_pending_next;
    logic [15:0]      digits_reg, digits_next;
    logic             overflow_reg, overflow_next;
    logic             done_reg, done_next;
    logic [15:0]      scratch_adj;

    // Add-3 correction per nibble, all evaluated on the pre-shift scratch.
    // Nibbles never exceed 9 here, so the 4-bit sum cannot carry out.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign scratch_adj[gi*4 +: 4] =
                (scratch_reg[gi*4 +: 4] >= 4'd5) ? scratch_reg[gi*4 +: 4] + 4'd3
                                                 : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            bin_reg         <= '0;
            scratch_reg     <= '0;
            cnt_reg         <= '0;
            ovf_pending_reg <= 1'b0;
            digits_reg      <= '0;
            overflow_reg    <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bin_reg         <= bin_next;
            scratch_reg     <= scratch_next;
            cnt_reg         <= cnt_next;
            ovf_pending_reg <= ovf_pending_next;
            digits_reg      <= digits_next;
            overflow_reg    <= overflow_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        bin_next         = bin_reg;
        scratch_next     = scratch_reg;
        cnt_next         = cnt_reg;
        ovf_pending_next = ovf_pending_reg;
        digits_next      = digits_reg;
        overflow_next    = overflow_reg;
        done_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    bin_next         = bus.bin;
                    scratch_next     = '0;
                    cnt_next         = CNT_LOAD;
                    ovf_pending_next = (bus.bin > MAX_VAL);
                    state_next       = SHIFT;
                end
            end
            SHIFT: begin
                // Shift the corrected scratch and the binary register as one word.
                scratch_next = {scratch_adj[14:0], bin_reg[BIN_W-1]};
                bin_next     = {bin_reg[BIN_W-2:0], 1'b0};
                cnt_next     = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                digits_next   = ovf_pending_reg ? SAT_BCD : scratch_reg;
                overflow_next = ovf_pending_reg;
                done_next     = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = done_reg;
    assign bus.overflow = overflow_reg;
    assign bus.one      = digits_reg[3:0];
    assign bus.ten      = digits_reg[7:4];
    assign bus.hunnid   = digits_reg[11:8];
    assign bus.thousand = digits_reg[15:12];
endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter: hand-computed vectors,
// overflow saturation, start/bin hazards, mid-conversion reset and a sweep.
module tb_bcd_converter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    bcd_converter_if bus ();

    bcd_converter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] digits();
        return {bus.thousand, bus.hunnid, bus.ten, bus.one};
    endfunction

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Issue one conversion from a falling edge and check result and timing.
    task automatic convert(input logic [13:0] v, input logic [15:0] exp_d, input logic exp_ovf);
        int n;
        int busy_n;
        n = 0;
        busy_n = 0;
        bus.bin = v;
        bus.start = 1'b1;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (bus.busy) busy_n++;
        end while (!bus.done && n < 40);
        check("done_seen", 32'(bus.done), 32'd1);
        check("latency", n - 1, 15);
        check("busy_cycles", busy_n, 15);
        check("digits", 32'(digits()), 32'(exp_d));
        check("overflow", 32'(bus.overflow), 32'(exp_ovf));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        $display("conv bin=%0d -> %h ovf=%0b latency=%0d", v, digits(), bus.overflow, n - 1);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v;
        logic [15:0] prev_exp;
        logic [15:0] exp_d;

        bus.start = 1'b0;
        bus.bin = '0;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits()), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(14'd0,     16'h0000, 1'b0);
        convert(14'd1234,  16'h1234, 1'b0);
        convert(14'd9999,  16'h9999, 1'b0);
        convert(14'd1000,  16'h1000, 1'b0);
        convert(14'd10000, 16'h9999, 1'b1);
        convert(14'd16383, 16'h9999, 1'b1);
        convert(14'd42,    16'h0042, 1'b0);

        // Start pulse during SHIFT and a late bin change must be ignored.
        bus.bin = 14'd567;
        bus.start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.start = (n == 5);
            if (n == 5) bus.bin = 14'd888;
            if (n == 7) bus.bin = 14'd1111;
        end while (!bus.done && n < 40);
        check("hazard_latency", n - 1, 15);
        check("hazard_digits", 32'(digits()), 32'h0567);
        $display("conv bin=567 with stray start -> %h", digits());
        bus.bin = 14'd888;
        bus.start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end while (!bus.done && n < 40);
        check("b2b_spacing", n, 16);
        check("b2b_digits", 32'(digits()), 32'h0888);
        check("b2b_overflow", 32'(bus.overflow), 32'd0);
        $display("conv bin=888 back-to-back -> %h spacing=%0d", digits(), n);
        @(negedge clk);
        check("b2b_done_pulse", 32'(bus.done), 32'd0);

        // Reset in the middle of a conversion.
        convert(14'd321, 16'h0321, 1'b0);
        bus.bin = 14'd4095;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_digits", 32'(digits()), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_overflow", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        $display("reset mid-conversion -> %h busy=%0b", digits(), bus.busy);
        rst_n = 1'b1;
        convert(14'd50, 16'h0050, 1'b0);

        // Sweep with start held high; digits must hold between dones.
        prev_exp = 16'h0050;
        bus.start = 1'b1;
        for (int i = 0; i < 770; i++) begin
            v = (i == 769) ? 9999 : i * 13;
            bus.bin = 14'(v);
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (!bus.done) check("sweep_stable", 32'(digits()), 32'(prev_exp));
            end while (!bus.done && n < 40);
            exp_d = ref_bcd(v);
            check("sweep_gap", n, 16);
            check("sweep_digits", 32'(digits()), 32'(exp_d));
            check("sweep_overflow", 32'(bus.overflow), 32'd0);
            $display("sweep bin=%0d -> %h gap=%0d", v, digits(), n);
            prev_exp = exp_d;
        end
        bus.start = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
